// File: rtl/cmd_sequencer.sv
// Steps a downstream executor through command indices 0..NUM_CMDS-1, with a start/ready
// handshake, programmable inter-command interval, pause/single-pass modes and a watchdog.
module cmd_sequencer #(
  parameter int unsigned CMD_W    = 3,
  parameter int unsigned NUM_CMDS = 5,
  parameter int unsigned INTERVAL = 25000000,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             single_pass,
  input  logic             ready_command,
  output logic [CMD_W-1:0] command,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int unsigned IvW  = $clog2(INTERVAL + 1);
  localparam int unsigned WdW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          WdEn = (TIMEOUT > 0);

  localparam logic [CMD_W-1:0] LastCmd = CMD_W'(NUM_CMDS - 1);
  localparam logic [IvW-1:0]   IvLoad  = IvW'(INTERVAL - 1);
  localparam logic [WdW-1:0]   WdLast  = WdW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StSend, StWaitDone, StInterval} state_e;

  state_e           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [IvW-1:0]   timer_q, timer_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             wd_expired;
  logic             wrap;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    timer_d    = timer_q;
    wd_d       = wd_q;
    err_d      = err_q;
    done_d     = 1'b0;
    wrap       = (cmd_q == LastCmd);
    wd_expired = WdEn && (wd_q == WdLast);

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StSend;
          err_d   = 1'b0;
          wd_d    = '0;
        end
      end
      StSend: begin
        // Handshake progress takes priority over a coincident watchdog expiry.
        if (!ready_command) begin
          state_d = StWaitDone;
          wd_d    = WdEn ? wd_q + 1'b1 : wd_q;
        end else if (wd_expired) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          wd_d = WdEn ? wd_q + 1'b1 : wd_q;
        end
      end
      StWaitDone: begin
        if (ready_command) begin
          state_d = StInterval;
          timer_d = IvLoad;
        end else if (wd_expired) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          wd_d = WdEn ? wd_q + 1'b1 : wd_q;
        end
      end
      StInterval: begin
        if (timer_q == '0) begin
          cmd_d  = wrap ? '0 : cmd_q + 1'b1;
          done_d = wrap;
          if (wrap && single_pass) begin
            state_d = StIdle;
          end else if (enable) begin
            state_d = StSend;
            wd_d    = '0;
          end else begin
            // Pause: the advanced index is kept and resumes on the next enable.
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    start_d = (state_d == StSend);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      timer_q <= '0;
      wd_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      timer_q <= timer_d;
      wd_q    <= wd_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign command     = cmd_q;
  assign start       = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: behavioural executor, start-edge scoreboard of command
// indices, and timing checks on loop period, watchdog, pause, single pass and reset.
module tb_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       single_pass = 1'b0;
  logic       ready_command = 1'b1;
  logic [2:0] command, nw_command;
  logic       start, busy, done, timeout_err;
  logic       nw_start, nw_busy, nw_done, nw_err;

  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  int         ack_busy = 2;
  logic       stuck = 1'b0;
  logic [2:0] exp_q[$];

  cmd_sequencer #(.CMD_W(3), .NUM_CMDS(3), .INTERVAL(4), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .single_pass  (single_pass),
    .ready_command(ready_command),
    .command      (command),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  // Same stimulus, watchdog disabled.
  cmd_sequencer #(.CMD_W(3), .NUM_CMDS(3), .INTERVAL(4), .TIMEOUT(0)) dut_nw (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .single_pass  (single_pass),
    .ready_command(ready_command),
    .command      (nw_command),
    .start        (nw_start),
    .busy         (nw_busy),
    .done         (nw_done),
    .timeout_err  (nw_err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Executor: accepts a start by dropping ready, stays busy ack_busy cycles, then completes.
  initial begin
    int left = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ready_command = 1'b1;
        left = 0;
      end else if (stuck) begin
        ready_command = 1'b1;
      end else if (ready_command == 1'b0) begin
        if (left <= 1) ready_command = 1'b1;
        else left--;
      end else if (start) begin
        ready_command = 1'b0;
        left = ack_busy;
      end
    end
  end

  // Scoreboard: each start rising edge pops the expected index; done must coincide with 0.
  initial begin
    logic prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && start && !prev_start) begin
        if (exp_q.size() == 0) check("unexpected_start", 1, 0);
        else check("start_cmd", command, exp_q.pop_front());
      end
      prev_start = start;
      if (rst && done) begin
        check("done_cmd_zero", command, 0);
        done_cnt++;
      end
    end
  end

  task automatic wait_rise(input string tag, output int t);
    int n = 0;
    while (start !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    while (start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check({tag, "_rise_in_time"}, n < 40, 1);
    t = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin @(negedge clk); n++; end
    check({tag, "_idle_in_time"}, n < 60, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    check({tag, "_done_in_time"}, n < 60, 1);
  endtask

  initial begin
    int t[5];
    int t0;
    int n;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_command", command, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", timeout_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Continuous loop 0,1,2,0,1 then pause during command 1
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(0); exp_q.push_back(1);
    enable = 1'b1;
    for (int k = 0; k < 5; k++) wait_rise("loop", t[k]);
    enable = 1'b0;
    for (int k = 1; k < 5; k++) check("loop_period", t[k] - t[k-1], 7);
    wait_idle("pause");
    check("pause_command", command, 2);
    check("pause_start", start, 0);
    check("pause_done_cnt", done_cnt, 1);
    repeat (5) @(negedge clk);
    check("pause_hold_start", start, 0);
    check("pause_hold_busy", busy, 0);

    // Resume from 2 in single-pass mode: wrap ends the pass
    single_pass = 1'b1;
    exp_q.push_back(2);
    enable = 1'b1;
    wait_rise("resume", t0);
    wait_done("resume");
    check("sp_wrap_busy", busy, 0);
    check("sp_wrap_command", command, 0);
    check("sp_wrap_start", start, 0);
    enable = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("sp_done_cnt", done_cnt, 2);

    // Full single pass 0,1,2 with enable held high: immediate restart after wrap
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) wait_rise("sp", t[k]);
    wait_done("sp");
    check("sp_end_busy", busy, 0);
    check("sp_end_command", command, 0);
    exp_q.push_back(0);
    @(negedge clk);
    check("sp_restart_start", start, 1);
    enable = 1'b0;
    wait_idle("sp_restart");
    check("sp_restart_command", command, 1);
    check("sp_restart_done_cnt", done_cnt, 3);

    // Watchdog: executor never accepts
    stuck = 1'b1;
    exp_q.push_back(1);
    enable = 1'b1;
    wait_rise("wd", t0);
    enable = 1'b0;
    n = 0;
    while (timeout_err !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check("wd_latency", cyc - t0, 8);
    check("wd_start", start, 0);
    check("wd_busy", busy, 0);
    check("wd_command", command, 1);
    stuck = 1'b0;
    exp_q.push_back(1);
    enable = 1'b1;
    wait_rise("wd_retry", t0);
    check("wd_retry_err_clr", timeout_err, 0);
    enable = 1'b0;
    wait_idle("wd_retry");
    check("wd_retry_command", command, 2);

    // Ack on the exact watchdog expiry cycle, then one cycle too late
    ack_busy = 7;
    exp_q.push_back(2);
    enable = 1'b1;
    wait_rise("coinc", t0);
    enable = 1'b0;
    wait_idle("coinc");
    check("coinc_err", timeout_err, 0);
    check("coinc_command", command, 0);
    check("coinc_done_cnt", done_cnt, 4);
    ack_busy = 8;
    exp_q.push_back(0);
    enable = 1'b1;
    wait_rise("late", t0);
    enable = 1'b0;
    wait_idle("late");
    check("late_err", timeout_err, 1);
    check("late_command", command, 0);
    repeat (10) @(negedge clk);

    // Reset during the interval of command 1
    ack_busy = 2;
    single_pass = 1'b0;
    exp_q.push_back(0); exp_q.push_back(1);
    enable = 1'b1;
    wait_rise("mid", t0);
    wait_rise("mid", t0);
    repeat (4) @(negedge clk);
    check("mid_command", command, 1);
    check("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("arst_command", command, 0);
    check("arst_start", start, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", timeout_err, 0);

    // Restart from 0 with a stuck executor; the watchdog-less copy never flags
    stuck = 1'b1;
    @(negedge clk);
    exp_q.push_back(0);
    rst = 1'b1;
    wait_rise("post_rst", t0);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_err", timeout_err, 1);
    check("post_rst_command", command, 0);
    check("nowd_err", nw_err, 0);
    check("nowd_busy", nw_busy, 1);
    check("nowd_start", nw_start, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, observed hang, expected finish");
    $fatal(1, "global timeout");
  end

endmodule
